// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: fetch FSM states, PC step, NOP word, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package legv8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [63:0] PC_STEP          = 64'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

    // Sequential fetch address; 64-bit unsigned, wraps silently at 2^64.
    function automatic logic [63:0] pc_next(input logic [63:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with clear > hold > load priority.
// Latency: one cycle from load to outputs.
// Backpressure: hold freezes contents; with neither hold nor load a bubble (valid=0) is inserted.
module if_id_reg
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [63:0] load_pc,
    output logic [31:0] Instruction,
    output logic [63:0] pc_out,
    output logic        if_valid
);

    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    // Next IF/ID contents. When the upstream has nothing new and decode is not
    // held, the entry is marked dead so decode never executes a word twice.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear) begin
            instr_d = NOP_INSTR;
            pc_d    = 64'h0;
            valid_d = 1'b0;
        end else if (hold) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            valid_d = valid_q;
        end else if (load) begin
            instr_d = load_instr;
            pc_d    = load_pc;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // IF/ID state flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 64'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign Instruction = instr_q;
    assign pc_out      = pc_q;
    assign if_valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction fetch: owns the PC, drives the imem req/ack handshake, feeds IF/ID.
// Latency: one instruction per cycle with zero-wait memory; IF/ID updates at the edge ending the ack cycle.
// Backpressure: stall freezes PC and IF/ID, parks an acked word in a hold buffer. IF_PERF_COUNTERS_EN adds counters.
module if_stage
    import legv8_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        IF_Flush,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [63:0] pc_out,
    output logic        if_valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  req_addr_q, req_addr_d;
    logic [31:0]  hold_q, hold_d;
    logic         imem_req_q, imem_req_d;

    logic         idr_load;
    logic [31:0]  idr_instr;
    logic [63:0]  idr_pc;

    // Fetch FSM next-state. A redirect never moves an address that is still
    // waiting for its ack; DRAIN lets that request finish and drops its data.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_d     = hold_q;
        idr_load   = 1'b0;
        idr_instr  = imem_rdata;
        idr_pc     = req_addr_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (branch_taken) begin
                    pc_d       = branch_target;
                    req_addr_d = branch_target;
                end else begin
                    req_addr_d = pc_q;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    pc_d = branch_target;
                    if (imem_ack) begin
                        req_addr_d = branch_target;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        hold_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        idr_load   = 1'b1;
                        pc_d       = pc_next(pc_q);
                        req_addr_d = pc_next(pc_q);
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d       = branch_target;
                    req_addr_d = branch_target;
                    state_d    = REQ;
                end else if (!stall) begin
                    idr_load   = 1'b1;
                    idr_instr  = hold_q;
                    idr_pc     = pc_q;
                    pc_d       = pc_next(pc_q);
                    req_addr_d = pc_next(pc_q);
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    pc_d = branch_target;
                end
                if (imem_ack) begin
                    req_addr_d = pc_d;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        imem_req_d = (state_d == REQ) || (state_d == DRAIN);
    end

    // Fetch FSM, PC, request address and hold buffer; reset abandons any handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_q     <= NOP_INSTR;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .clear       (IF_Flush | branch_taken),
        .hold        (stall),
        .load        (idr_load),
        .load_instr  (idr_instr),
        .load_pc     (idr_pc),
        .Instruction (Instruction),
        .pc_out      (pc_out),
        .if_valid    (if_valid)
    );

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((IF_Flush | branch_taken) && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Counter flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= 32'h0;
            flush_count_q  <= 32'h0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scripted memory responses, scoreboard of expected IF/ID loads.
// Latency: n/a.
// Backpressure: n/a.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        IF_Flush;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [63:0] pc_out;
    logic        if_valid;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_addr;
    int          total;
    int          bad;

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .IF_Flush      (IF_Flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .Instruction   (Instruction),
        .pc_out        (pc_out),
        .if_valid      (if_valid)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return 32'hD000_0000 ^ a[31:0] ^ {a[63:60], 28'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h0 || Instruction !== 32'h0 ||
            pc_out !== 64'h0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: req=%0b addr=%h instr=%h pc=%h vld=%0b want all zero",
                     imem_req, imem_addr, Instruction, pc_out, if_valid);
        end
        reset = 1'b1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: req=%0b want 0", imem_req);
        end
        tick();
        exp_addr = 64'h0;
    endtask

    // Zero-wait memory: ack every request with the address-derived word.
    task automatic test_zero_wait(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                bad++;
                $display("FAIL zw_req: req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_addr);
            end
            imem_ack   = 1'b1;
            imem_rdata = word_at(exp_addr);
            sb.push_back('{pc: exp_addr, instr: word_at(exp_addr)});
            tick();
            imem_ack = 1'b0;
            total++;
            if (if_valid !== 1'b1 || sb.size() == 0) begin
                bad++;
                $display("FAIL zw_valid: vld=%0b sb=%0d want vld=1", if_valid, sb.size());
            end else begin
                e = sb.pop_front();
                total++;
                if (pc_out !== e.pc || Instruction !== e.instr) begin
                    bad++;
                    $display("FAIL zw_data: pc=%h instr=%h want pc=%h instr=%h", pc_out, Instruction, e.pc, e.instr);
                end
            end
            exp_addr = exp_addr + 64'd4;
        end
    endtask

    task automatic test_delayed_ack();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin
                bad++;
                $display("FAIL dly_hold_addr: cyc=%0d req=%0b addr=%h want req=1 addr=10", i, imem_req, imem_addr);
            end
            tick();
            total++;
            if (if_valid !== 1'b0) begin
                bad++;
                $display("FAIL dly_bubble: cyc=%0d vld=%0b want 0", i, if_valid);
            end
        end
        total++;
        if (imem_addr !== 64'h10) begin
            bad++;
            $display("FAIL dly_ack_addr: addr=%h want 10", imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word_at(64'h10);
        sb.push_back('{pc: 64'h10, instr: word_at(64'h10)});
        tick();
        imem_ack = 1'b0;
        total++;
        if (if_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL dly_valid: vld=%0b want 1", if_valid);
        end else begin
            e = sb.pop_front();
            total++;
            if (pc_out !== e.pc || Instruction !== e.instr) begin
                bad++;
                $display("FAIL dly_data: pc=%h instr=%h want pc=%h instr=%h", pc_out, Instruction, e.pc, e.instr);
            end
        end
        exp_addr = 64'h14;
    endtask

    task automatic test_stall_hold();
        exp_t e;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h20) begin
            bad++;
            $display("FAIL st_req: req=%0b addr=%h want req=1 addr=20", imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word_at(64'h20);
        stall      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            imem_ack = 1'b0;
            total++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || pc_out !== 64'h1C ||
                Instruction !== word_at(64'h1C)) begin
                bad++;
                $display("FAIL st_hold: cyc=%0d req=%0b vld=%0b pc=%h instr=%h want req=0 vld=1 pc=1c instr=%h",
                         i, imem_req, if_valid, pc_out, Instruction, word_at(64'h1C));
            end
        end
        stall = 1'b0;
        sb.push_back('{pc: 64'h20, instr: word_at(64'h20)});
        tick();
        total++;
        if (if_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL st_release_vld: vld=%0b want 1", if_valid);
        end else begin
            e = sb.pop_front();
            total++;
            if (pc_out !== e.pc || Instruction !== e.instr) begin
                bad++;
                $display("FAIL st_release_data: pc=%h instr=%h want pc=%h instr=%h", pc_out, Instruction, e.pc, e.instr);
            end
        end
        exp_addr = 64'h24;
    endtask

    task automatic test_redirect_drain();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h40) begin
            bad++;
            $display("FAIL rd_req: req=%0b addr=%h want req=1 addr=40", imem_req, imem_addr);
        end
        branch_taken  = 1'b1;
        branch_target = 64'h100;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (if_valid !== 1'b0 || Instruction !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 64'h40) begin
                bad++;
                $display("FAIL rd_drain: cyc=%0d vld=%0b instr=%h req=%0b addr=%h want vld=0 instr=0 req=1 addr=40",
                         i, if_valid, Instruction, imem_req, imem_addr);
            end
            if (i == 1) begin
                imem_ack   = 1'b1;
                imem_rdata = word_at(64'h40);
            end
            tick();
            imem_ack = 1'b0;
        end
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
            bad++;
            $display("FAIL rd_target: vld=%0b req=%0b addr=%h want vld=0 req=1 addr=100", if_valid, imem_req, imem_addr);
        end
        exp_addr = 64'h100;
        test_zero_wait(1);
    endtask

    // Redirect on an acked cycle to the top of the address space, then wrap to 0.
    task automatic test_wrap();
        total++;
        if (imem_addr !== 64'h104) begin
            bad++;
            $display("FAIL wr_req: addr=%h want 104", imem_addr);
        end
        imem_ack      = 1'b1;
        imem_rdata    = word_at(64'h104);
        branch_taken  = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            bad++;
            $display("FAIL wr_redirect: vld=%0b req=%0b addr=%h want vld=0 req=1 addr=fffffffffffffffc",
                     if_valid, imem_req, imem_addr);
        end
        exp_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        test_zero_wait(2);
    endtask

    task automatic test_stall_flush();
        reset = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: req=%0b addr=%h vld=%0b want 0/0/0", imem_req, imem_addr, if_valid);
        end
        tick();
        reset = 1'b1;
        tick();
        exp_addr = 64'h0;
        test_zero_wait(1);
        stall    = 1'b1;
        IF_Flush = 1'b1;
        tick();
        stall    = 1'b0;
        IF_Flush = 1'b0;
        total++;
        if (Instruction !== 32'h0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL sf_clear: instr=%h vld=%0b want instr=0 vld=0", Instruction, if_valid);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin
            bad++;
            $display("FAIL sf_fsm: req=%0b addr=%h want req=1 addr=4", imem_req, imem_addr);
        end
`ifdef IF_PERF_COUNTERS_EN
        total++;
        if (stall_cycles !== 32'd1 || flush_count !== 32'd1) begin
            bad++;
            $display("FAIL sf_perf: stall_cycles=%0d flush_count=%0d want 1/1", stall_cycles, flush_count);
        end
`endif
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        stall         = 1'b0;
        IF_Flush      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        exp_addr      = 64'h0;

        test_reset();
        test_zero_wait(4);
        test_delayed_ack();
        test_zero_wait(3);
        test_stall_hold();
        test_zero_wait(7);
        test_redirect_drain();
        test_wrap();
        test_stall_flush();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: entries=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
